// File: rtl/ycbcr_pkg.sv
// ycbcr_pkg: widths, symbol-slot indices and FSM states for the 4:2:2 to 4:4:4 upsampler
package ycbcr_pkg;
  localparam int SYM_W = 8;
  localparam int PAIR422_W = 4 * SYM_W;
  localparam int PAIR444_W = 6 * SYM_W;
  // Field offsets in symbols; multiply by the symbol width for bit positions
  localparam int Y0_IDX = 0;
  localparam int CB422_IDX = 1;
  localparam int Y1_IDX = 2;
  localparam int CR422_IDX = 3;
  localparam int Y_IDX = 0;
  localparam int CB_IDX = 1;
  localparam int CR_IDX = 2;
  typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/ycbcr422_to_444_2pix_chroma_avg.sv
// chroma_avg: rounding average (a + b + 1) >> 1 of two W-bit samples
module chroma_avg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  logic [W:0] sum;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};
    y = sum[W:1];
  end
endmodule

// File: rtl/ycbcr422_to_444_2pix.sv
// ycbcr422_to_444_2pix: 2-pixel/clock 4:2:2 to 4:4:4 chroma upsampler, 2-clock latency.
// Define YCBCR_CHROMA_INTERP_EN to interpolate odd-pixel chroma; otherwise it is replicated.
module ycbcr422_to_444_2pix
  import ycbcr_pkg::*;
#(
  parameter int BIT_PER_SYMBLE = 8,
  parameter int PIXCEL_NUM = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PIXCEL_NUM*2*BIT_PER_SYMBLE-1:0] ycbcr422_din,
  input  logic [PIXCEL_NUM-1:0]             ycbcr422_h_sync,
  input  logic [PIXCEL_NUM-1:0]             ycbcr422_v_sync,
  input  logic [PIXCEL_NUM-1:0]             ycbcr422_de,
  output logic [PIXCEL_NUM*3*BIT_PER_SYMBLE-1:0] ycbcr_dout,
  output logic [PIXCEL_NUM-1:0]             ycbcr_h_sync,
  output logic [PIXCEL_NUM-1:0]             ycbcr_v_sync,
  output logic [PIXCEL_NUM-1:0]             ycbcr_de
);
  localparam int B = BIT_PER_SYMBLE;
  if (PIXCEL_NUM != 2) begin : g_pix_err
    $error("ycbcr422_to_444_2pix supports PIXCEL_NUM == 2 only");
  end
  logic [4*B-1:0] din1_d, din1_q;
  logic [1:0] hs1_d, hs1_q, vs1_d, vs1_q, de1_d, de1_q;
  logic [6*B-1:0] dout_d, dout_q;
  logic [1:0] hs2_d, hs2_q, vs2_d, vs2_q, de2_d, de2_q;
  state_t state_d, state_q;
  logic [B-1:0] y0, cb, y1, cr, cb1, cr1;
`ifdef YCBCR_CHROMA_INTERP_EN
  logic [B-1:0] cb_avg, cr_avg;
  logic interp;
  chroma_avg #(.W(B)) u_cb_avg (.a(cb), .b(ycbcr422_din[CB422_IDX*B +: B]), .y(cb_avg));
  chroma_avg #(.W(B)) u_cr_avg (.a(cr), .b(ycbcr422_din[CR422_IDX*B +: B]), .y(cr_avg));
`endif
  always_comb begin
    din1_d = ycbcr422_din;
    hs1_d = ycbcr422_h_sync;
    vs1_d = ycbcr422_v_sync;
    de1_d = ycbcr422_de;
    // ACTIVE exactly when S1 holds a valid pair
    state_d = ycbcr422_de[0] ? ACTIVE : IDLE;
    y0 = din1_q[Y0_IDX*B +: B];
    cb = din1_q[CB422_IDX*B +: B];
    y1 = din1_q[Y1_IDX*B +: B];
    cr = din1_q[CR422_IDX*B +: B];
`ifdef YCBCR_CHROMA_INTERP_EN
    // A lookahead pair exists only when the next input is also valid; else replicate
    interp = (state_q == ACTIVE) && ycbcr422_de[0];
    cb1 = interp ? cb_avg : cb;
    cr1 = interp ? cr_avg : cr;
`else
    cb1 = cb;
    cr1 = cr;
`endif
    dout_d = (state_q == ACTIVE) ? {cr1, cb1, y1, cr, cb, y0} : '0;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    de2_d = de1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      din1_q <= '0;
      hs1_q <= '0;
      vs1_q <= '0;
      de1_q <= '0;
      state_q <= IDLE;
      dout_q <= '0;
      hs2_q <= '0;
      vs2_q <= '0;
      de2_q <= '0;
    end else begin
      din1_q <= din1_d;
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
      de1_q <= de1_d;
      state_q <= state_d;
      dout_q <= dout_d;
      hs2_q <= hs2_d;
      vs2_q <= vs2_d;
      de2_q <= de2_d;
    end
  end
  assign ycbcr_dout = dout_q;
  assign ycbcr_h_sync = hs2_q;
  assign ycbcr_v_sync = vs2_q;
  assign ycbcr_de = de2_q;
endmodule

// File: tb/tb_ycbcr422_to_444_2pix.sv
// tb_ycbcr422_to_444_2pix: scoreboard bench for the 4:2:2 to 4:4:4 upsampler (honours YCBCR_CHROMA_INTERP_EN)
module tb_ycbcr422_to_444_2pix;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] din;
  logic [1:0] hs, vs, de;
  logic [47:0] ycbcr_dout;
  logic [1:0] ycbcr_h_sync, ycbcr_v_sync, ycbcr_de;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [47:0] d;
    logic [1:0] h;
    logic [1:0] v;
    logic [1:0] e;
  } out_t;
  out_t exp_q[$];
  logic [31:0] c_din = '0;
  logic [1:0] c_hs = '0, c_vs = '0, c_de = '0;
  logic [7:0] cb1_log[$];
  logic [7:0] cr1_log[$];

  ycbcr422_to_444_2pix #(.BIT_PER_SYMBLE(8), .PIXCEL_NUM(2)) dut (
    .clk(clk), .rst(rst),
    .ycbcr422_din(din), .ycbcr422_h_sync(hs), .ycbcr422_v_sync(vs), .ycbcr422_de(de),
    .ycbcr_dout(ycbcr_dout), .ycbcr_h_sync(ycbcr_h_sync), .ycbcr_v_sync(ycbcr_v_sync), .ycbcr_de(ycbcr_de)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    return 8'((int'(a) + int'(b) + 1) / 2);
  endfunction

  function automatic logic [31:0] pair(input logic [7:0] cb, input logic [7:0] cr);
    return {cr, 8'($urandom), cb, 8'($urandom)};
  endfunction

  task automatic step(input logic r, input logic [31:0] d, input logic [1:0] e);
    out_t x, got;
    logic [7:0] cb1, cr1;
    rst = r;
    din = d;
    de = e;
    hs = 2'($urandom);
    vs = 2'($urandom);
    x = '0;
    if (!r) begin
      x.h = c_hs;
      x.v = c_vs;
      x.e = c_de;
      if (c_de[0]) begin
        cb1 = c_din[15:8];
        cr1 = c_din[31:24];
`ifdef YCBCR_CHROMA_INTERP_EN
        if (e[0]) begin
          cb1 = avg(c_din[15:8], d[15:8]);
          cr1 = avg(c_din[31:24], d[31:24]);
        end
`endif
        x.d = {cr1, cb1, c_din[23:16], c_din[31:24], c_din[15:8], c_din[7:0]};
      end
    end
    exp_q.push_back(x);
    {c_din, c_hs, c_vs, c_de} = r ? 36'd0 : {d, hs, vs, e};
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    got = {ycbcr_dout, ycbcr_h_sync, ycbcr_v_sync, ycbcr_de};
    checks++;
    assert (got === x) else begin
      errors++;
      $error("FAIL out: got %h expected %h", got, x);
    end
    if (ycbcr_de[0]) begin
      cb1_log.push_back(ycbcr_dout[39:32]);
      cr1_log.push_back(ycbcr_dout[47:40]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'($urandom), 2'b00);
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic chk_len(input string tag, input int want);
    checks++;
    assert (cb1_log.size() == want) else begin
      errors++;
      $error("FAIL %s: got %0d logged pairs expected %0d", tag, cb1_log.size(), want);
    end
  endtask

  task automatic clr();
    cb1_log.delete();
    cr1_log.delete();
  endtask

  logic [7:0] e_cb[4], e_cr[4], e_gap[4], e_rnd[3], e_rst[2];

  initial begin
`ifdef YCBCR_CHROMA_INTERP_EN
    e_cb = '{8'd101, 8'd103, 8'd105, 8'd106};
    e_cr = '{8'd199, 8'd197, 8'd195, 8'd194};
    e_gap = '{8'd15, 8'd20, 8'd95, 8'd100};
    e_rnd = '{8'd101, 8'd255, 8'd1};
    e_rst = '{8'd35, 8'd40};
`else
    e_cb = '{8'd100, 8'd102, 8'd104, 8'd106};
    e_cr = '{8'd200, 8'd198, 8'd196, 8'd194};
    e_gap = '{8'd10, 8'd20, 8'd90, 8'd100};
    e_rnd = '{8'd100, 8'd255, 8'd0};
    e_rst = '{8'd30, 8'd40};
`endif
    rst = 1'b1;
    din = '0;
    hs = '0;
    vs = '0;
    de = '0;
    for (int i = 0; i < 3; i++) step(1'b1, 32'($urandom), 2'($urandom));
    idle(3);
    clr();
    step(1'b0, pair(8'd100, 8'd200), 2'b11);
    step(1'b0, pair(8'd102, 8'd198), 2'b11);
    step(1'b0, pair(8'd104, 8'd196), 2'b11);
    step(1'b0, pair(8'd106, 8'd194), 2'b11);
    idle(3);
    chk_len("interp_len", 4);
    for (int i = 0; i < 4; i++) begin
      chk8($sformatf("interp_cb1[%0d]", i), cb1_log[i], e_cb[i]);
      chk8($sformatf("interp_cr1[%0d]", i), cr1_log[i], e_cr[i]);
    end
    clr();
    step(1'b0, pair(8'd100, 8'd0), 2'b11);
    step(1'b0, pair(8'd101, 8'd0), 2'b11);
    idle(2);
    step(1'b0, pair(8'd255, 8'd255), 2'b11);
    step(1'b0, pair(8'd255, 8'd255), 2'b11);
    idle(2);
    step(1'b0, pair(8'd0, 8'd0), 2'b11);
    step(1'b0, pair(8'd1, 8'd1), 2'b11);
    idle(3);
    chk_len("round_len", 6);
    for (int i = 0; i < 3; i++) chk8($sformatf("round_cb1[%0d]", i), cb1_log[2*i], e_rnd[i]);
    clr();
    step(1'b0, pair(8'd50, 8'd60), 2'b11);
    idle(3);
    chk_len("single_len", 1);
    chk8("single_cb1", cb1_log[0], 8'd50);
    chk8("single_cr1", cr1_log[0], 8'd60);
    clr();
    step(1'b0, pair(8'd10, 8'd10), 2'b11);
    step(1'b0, pair(8'd20, 8'd20), 2'b11);
    step(1'b0, pair(8'd250, 8'd250), 2'b10);
    step(1'b0, pair(8'd90, 8'd90), 2'b11);
    step(1'b0, pair(8'd100, 8'd100), 2'b11);
    idle(3);
    chk_len("gap_len", 4);
    for (int i = 0; i < 4; i++) chk8($sformatf("gap_cb1[%0d]", i), cb1_log[i], e_gap[i]);
    step(1'b0, pair(8'd200, 8'd200), 2'b11);
    step(1'b0, pair(8'd210, 8'd210), 2'b11);
    step(1'b0, pair(8'd220, 8'd220), 2'b11);
    step(1'b1, pair(8'd230, 8'd230), 2'b11);
    step(1'b1, pair(8'd240, 8'd240), 2'b11);
    step(1'b1, pair(8'd250, 8'd250), 2'b11);
    clr();
    idle(2);
    step(1'b0, pair(8'd30, 8'd30), 2'b11);
    step(1'b0, pair(8'd40, 8'd40), 2'b11);
    idle(3);
    chk_len("rst_len", 2);
    for (int i = 0; i < 2; i++) chk8($sformatf("rst_cb1[%0d]", i), cb1_log[i], e_rst[i]);
    for (int i = 0; i < 20; i++) step(1'b0, 32'($urandom), 2'($urandom));
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
